// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, memory and mux-select signals of the shared memory port
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic [AW-1:0] m0_addr;
  logic          m0_we;
  logic [DW-1:0] m0_wdata;
  logic          m0_ready;
  logic          m0_err;

  logic          m1_req;
  logic [AW-1:0] m1_addr;
  logic          m1_we;
  logic [DW-1:0] m1_wdata;
  logic          m1_ready;
  logic          m1_err;

  logic [DW-1:0] rdata;
  logic          sel;

  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  m0_req, m0_addr, m0_we, m0_wdata,
    input  m1_req, m1_addr, m1_we, m1_wdata,
    input  mem_ack, mem_rdata,
    output m0_ready, m0_err, m1_ready, m1_err,
    output rdata, sel, mem_req, mem_addr, mem_we, mem_wdata
  );

  // Requesters plus memory, as seen from outside the arbiter
  modport master (
    output m0_req, m0_addr, m0_we, m0_wdata,
    output m1_req, m1_addr, m1_we, m1_wdata,
    output mem_ack, mem_rdata,
    input  m0_ready, m0_err, m1_ready, m1_err,
    input  rdata, sel, mem_req, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin two-requester memory port arbiter with req/ack watchdog
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          ptr_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] mem_addr_q;
  logic          mem_we_q;
  logic [DW-1:0] mem_wdata_q;

  logic          busy;
  logic          done_ok;
  logic          done_err;
  logic [DW-1:0] rdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (state_d == BUSY0) begin
            mem_addr_q  <= bus.m0_addr;
            mem_we_q    <= bus.m0_we;
            mem_wdata_q <= bus.m0_wdata;
          end else if (state_d == BUSY1) begin
            mem_addr_q  <= bus.m1_addr;
            mem_we_q    <= bus.m1_we;
            mem_wdata_q <= bus.m1_wdata;
          end
        end
        default: begin
          // Pointer names the requester that wins the next tie: the one not just served.
          if (state_d == IDLE) ptr_q <= (state_q == BUSY0);
          else                 cnt_q <= cnt_q + CW'(1);
        end
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    done_ok  = 1'b0;
    done_err = 1'b0;
    rdata_d  = '0;
    case (state_q)
      IDLE: begin
        if (bus.m0_req && (!bus.m1_req || !ptr_q)) state_d = BUSY0;
        else if (bus.m1_req)                       state_d = BUSY1;
      end
      BUSY0, BUSY1: begin
        busy = 1'b1;
        // An ack in the final watchdog cycle still completes normally.
        if (bus.mem_ack) begin
          done_ok = 1'b1;
          rdata_d = bus.mem_rdata;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          done_err = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_req   = busy;
  assign bus.sel       = (state_q == BUSY1);
  assign bus.rdata     = rdata_d;
  assign bus.m0_ready  = done_ok  && (state_q == BUSY0);
  assign bus.m1_ready  = done_ok  && (state_q == BUSY1);
  assign bus.m0_err    = done_err && (state_q == BUSY0);
  assign bus.m1_err    = done_err && (state_q == BUSY1);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive point: just after the rising edge. Checks follow at drive point + 2.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    bus.m0_req = 0; bus.m0_addr = '0; bus.m0_we = 0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_addr = '0; bus.m1_we = 0; bus.m1_wdata = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    step();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 0;
    clear_inputs();

    // Reset state
    #2;
    check("rst_mem_req",   bus.mem_req,   0);
    check("rst_sel",       bus.sel,       0);
    check("rst_mem_we",    bus.mem_we,    0);
    check("rst_mem_addr",  bus.mem_addr,  0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_readyerr",  {bus.m0_ready, bus.m1_ready, bus.m0_err, bus.m1_err}, 0);
    step();
    rst_n = 1;

    // Zero-wait read by m0
    bus.m0_req = 1; bus.m0_addr = 32'h40; bus.m0_we = 0;
    settle();
    check("t1_idle_mem_req", bus.mem_req, 0);
    step();
    bus.mem_ack = 1; bus.mem_rdata = 32'hDEADBEEF;
    settle();
    check("t1_mem_req",  bus.mem_req,  1);
    check("t1_sel",      bus.sel,      0);
    check("t1_mem_addr", bus.mem_addr, 32'h40);
    check("t1_m0_ready", bus.m0_ready, 1);
    check("t1_rdata",    bus.rdata,    32'hDEADBEEF);
    check("t1_m0_err",   bus.m0_err,   0);
    check("t1_m1_ready", bus.m1_ready, 0);
    step();
    bus.m0_req = 0; bus.mem_ack = 0;
    settle();
    check("t1_back_idle", bus.mem_req, 0);
    check("t1_ready_low", bus.m0_ready, 0);
    check("t1_rdata_idle", bus.rdata, 0);

    // Both held from reset, 2-cycle memory: grants alternate
    do_reset();
    bus.m0_req = 1; bus.m0_addr = 32'h10;
    bus.m1_req = 1; bus.m1_addr = 32'h20;
    for (int g = 0; g < 4; g++) begin
      settle();
      check("t2_idle", bus.mem_req, 0);
      step();
      bus.mem_ack = 0;
      settle();
      check("t2_busy_req", bus.mem_req, 1);
      check("t2_sel", bus.sel, (g % 2));
      check("t2_addr", bus.mem_addr, (g % 2 == 0) ? 32'h10 : 32'h20);
      check("t2_no_ready", {bus.m0_ready, bus.m1_ready}, 0);
      step();
      bus.mem_ack = 1; bus.mem_rdata = 32'h1000 + g;
      settle();
      check("t2_m0_ready", bus.m0_ready, (g % 2 == 0));
      check("t2_m1_ready", bus.m1_ready, (g % 2 == 1));
      check("t2_rdata", bus.rdata, 32'h1000 + g);
      step();
      bus.mem_ack = 0;
    end
    bus.m0_req = 0; bus.m1_req = 0;
    settle();
    check("t2_end_idle", bus.mem_req, 0);

    // m1 write with inputs changing mid-transfer
    step();
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h100; bus.m1_wdata = 32'h12345678;
    step();
    bus.m1_addr = 32'h200; bus.m1_wdata = 32'hFFFF0000; bus.m1_we = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) bus.mem_ack = 1;
      settle();
      check("t3_sel",   bus.sel,       1);
      check("t3_addr",  bus.mem_addr,  32'h100);
      check("t3_wdata", bus.mem_wdata, 32'h12345678);
      check("t3_we",    bus.mem_we,    1);
      check("t3_ready", bus.m1_ready,  (c == 3));
      if (c < 3) step();
    end
    step();
    bus.m1_req = 0; bus.mem_ack = 0; bus.m1_we = 0;
    settle();
    check("t3_idle", bus.mem_req, 0);

    // Memory never acks: m0 times out, pending m1 follows
    step();
    bus.m0_req = 1; bus.m0_addr = 32'h80;
    bus.m1_req = 1; bus.m1_addr = 32'h84;
    for (int i = 1; i <= 16; i++) begin
      step();
      settle();
      check("t4_mem_req",  bus.mem_req,  1);
      check("t4_sel",      bus.sel,      0);
      check("t4_m0_ready", bus.m0_ready, 0);
      check("t4_m0_err",   bus.m0_err,   (i == 16));
      check("t4_m1_err",   bus.m1_err,   0);
    end
    step();
    bus.m0_req = 0;
    settle();
    check("t4_idle_req", bus.mem_req, 0);
    check("t4_idle_err", bus.m0_err,  0);
    step();
    bus.mem_ack = 1; bus.mem_rdata = 32'h5A5A5A5A;
    settle();
    check("t4_m1_sel",   bus.sel,      1);
    check("t4_m1_addr",  bus.mem_addr, 32'h84);
    check("t4_m1_ready", bus.m1_ready, 1);
    step();
    bus.m1_req = 0; bus.mem_ack = 0;

    // Ack coincides with the timeout cycle
    step();
    bus.m0_req = 1; bus.m0_addr = 32'h90;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 16) begin
        bus.mem_ack = 1; bus.mem_rdata = 32'hCAFEF00D;
      end
      settle();
      if (i < 16) check("t5_wait_ready", bus.m0_ready, 0);
    end
    check("t5_ready", bus.m0_ready, 1);
    check("t5_err",   bus.m0_err,   0);
    check("t5_rdata", bus.rdata,    32'hCAFEF00D);
    step();
    bus.m0_req = 0; bus.mem_ack = 0;
    settle();
    check("t5_idle", bus.mem_req, 0);

    // Reset during BUSY1 with an ack about to arrive
    step();
    bus.m1_req = 1; bus.m1_addr = 32'hA0;
    step();
    settle();
    check("t6_busy1_sel", bus.sel, 1);
    rst_n = 0;
    bus.mem_ack = 1; bus.mem_rdata = 32'h77777777;
    #1;
    check("t6_rst_mem_req", bus.mem_req, 0);
    check("t6_rst_sel",     bus.sel,     0);
    check("t6_rst_flags",   {bus.m0_ready, bus.m1_ready, bus.m0_err, bus.m1_err}, 0);
    step();
    bus.m0_req = 1; bus.m0_addr = 32'hB0;
    rst_n = 1;
    settle();
    check("t6_post_idle",  bus.mem_req, 0);
    check("t6_post_flags", {bus.m0_ready, bus.m1_ready, bus.m0_err, bus.m1_err}, 0);
    step();
    settle();
    check("t6_grant_sel",  bus.sel,      0);
    check("t6_grant_addr", bus.mem_addr, 32'hB0);
    check("t6_m0_ready",   bus.m0_ready, 1);
    step();
    clear_inputs();
    settle();
    check("t6_final_idle", bus.mem_req, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
